// File: rtl/alink_rx_arb_pkg.sv
// alink_rx_arb_pkg: shared constants for the ALINK RX write-port arbiter.
// Holds the arbiter state encodings, the report header tag and the header
// word builder used when ALINK_RX_HDR_EN is defined.
package alink_rx_arb_pkg;

   typedef logic [1:0] rxa_state_t;

   localparam rxa_state_t RXA_IDLE = 2'd0;
   localparam rxa_state_t RXA_XFER = 2'd1;
   localparam rxa_state_t RXA_DONE = 2'd2;

   localparam logic [7:0] RXA_HDR_TAG = 8'hA1;

   // Header word preceding a report: tag, granted PHY index, report sequence.
   function automatic logic [31:0] rxa_hdr_word(input logic [4:0] phy, input logic [15:0] seq);
      return {RXA_HDR_TAG, 3'b000, phy, seq};
   endfunction

endpackage

// File: rtl/alink_rx_arb_rr_pick.sv
// alink_rx_arb_rr_pick: combinational round-robin picker (rr_pick).
// Returns the first requesting index found searching upward from last+1,
// wrapping modulo PHY_NUM. 'found' is low when no bit of req is set.
module alink_rx_arb_rr_pick
   import alink_rx_arb_pkg::*;
#(
   parameter int PHY_NUM = 32
) (
   input  logic [PHY_NUM-1:0] req,
   input  logic [4:0]         last,
   output logic               found,
   output logic [4:0]         next
);

   // Pick the requester at the smallest wrapped distance after 'last'.
   always_comb begin
      int d;
      int best;
      found = 1'b0;
      next  = last;
      best  = PHY_NUM;
      d     = 0;
      for (int j = 0; j < PHY_NUM; j++) begin
         d = j - int'(last) - 1;
         if (d < 0) d = d + PHY_NUM;
         if (req[j] && (d < best)) begin
            best  = d;
            found = 1'b1;
            next  = 5'(j);
         end
      end
   end

endmodule

// File: rtl/alink_rx_arb.sv
// alink_rx_arb: round-robin sequencer sharing the RX FIFO write port among
// PHY_NUM per-PHY report buffers. A whole report is streamed per grant,
// only when the FIFO can absorb two reports' worth of words (in-flight slack).
// Optional feature: define ALINK_RX_HDR_EN to prefix each report with a
// header word {8'hA1, 3'b0, cur_phy, seq}.
module alink_rx_arb
   import alink_rx_arb_pkg::*;
#(
   parameter int PHY_NUM    = 32,
   parameter int RPT_LEN    = 8,
   parameter int FIFO_DEPTH = 512,
   parameter int CNT_W      = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   reg_flush,
   input  logic [PHY_NUM-1:0]     reg_mask,
   input  logic [PHY_NUM-1:0]     phy_req,
   input  logic [32*PHY_NUM-1:0]  phy_dat,
   output logic [PHY_NUM-1:0]     phy_pop,
   input  logic [CNT_W-1:0]       rx_data_count,
   output logic                   rx_vld,
   output logic [31:0]            rx_dat,
   output logic [4:0]             cur_phy,
   output logic [31:0]            rpt_cnt,
   output logic                   proto_err
);

`ifdef ALINK_RX_HDR_EN
   localparam int LEN = RPT_LEN + 1;
`else
   localparam int LEN = RPT_LEN;
`endif
   localparam int WCNT_W = $clog2(LEN + 1);
   localparam int SPC_W  = CNT_W + 2;

   rxa_state_t        state;
   logic [WCNT_W-1:0] wcnt;
   logic [PHY_NUM-1:0] elig;
   logic              grant_found;
   logic [4:0]        grant_idx;
   logic [SPC_W-1:0]  fill_need;
   logic              space_ok;
   logic [31:0]       sel_dat;
   logic              req_cur;
   logic              hdr_cycle;
`ifdef ALINK_RX_HDR_EN
   logic [15:0]       seq;
`endif

   assign elig      = phy_req & ~reg_mask;
   assign fill_need = SPC_W'(rx_data_count) + SPC_W'(2 * LEN);
   assign space_ok  = (fill_need <= SPC_W'(FIFO_DEPTH));

`ifdef ALINK_RX_HDR_EN
   assign hdr_cycle = (wcnt == '0);
`else
   assign hdr_cycle = 1'b0;
`endif

   alink_rx_arb_rr_pick #(
      .PHY_NUM (PHY_NUM)
   ) u_rr_pick (
      .req   (elig),
      .last  (cur_phy),
      .found (grant_found),
      .next  (grant_idx)
   );

   // Select the granted PHY's head word and request, and strobe its pop on payload cycles.
   always_comb begin
      sel_dat = '0;
      req_cur = 1'b0;
      phy_pop = '0;
      for (int i = 0; i < PHY_NUM; i++) begin
         if (cur_phy == 5'(i)) begin
            sel_dat = phy_dat[32*i +: 32];
            req_cur = phy_req[i];
            if ((state == RXA_XFER) && !hdr_cycle) phy_pop[i] = 1'b1;
         end
      end
   end

   // Arbiter FSM: grant, count out LEN words, then a one-cycle DONE for req to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RXA_IDLE;
         cur_phy <= 5'(PHY_NUM - 1);
         wcnt    <= '0;
         rpt_cnt <= '0;
`ifdef ALINK_RX_HDR_EN
         seq     <= '0;
`endif
      end else if (reg_flush) begin
         state   <= RXA_IDLE;
         cur_phy <= 5'(PHY_NUM - 1);
         wcnt    <= '0;
         rpt_cnt <= '0;
`ifdef ALINK_RX_HDR_EN
         seq     <= '0;
`endif
      end else begin
         case (state)
            RXA_IDLE: begin
               if (grant_found && space_ok) begin
                  state   <= RXA_XFER;
                  cur_phy <= grant_idx;
                  wcnt    <= '0;
               end
            end
            RXA_XFER: begin
               wcnt <= wcnt + 1'b1;
               if (wcnt == WCNT_W'(LEN - 1)) state <= RXA_DONE;
            end
            RXA_DONE: begin
               rpt_cnt <= rpt_cnt + 32'd1;
`ifdef ALINK_RX_HDR_EN
               seq     <= seq + 16'd1;
`endif
               state   <= RXA_IDLE;
            end
            default: state <= RXA_IDLE;
         endcase
      end
   end

   // FIFO write port: one registered word per XFER cycle, zero when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_vld <= 1'b0;
         rx_dat <= '0;
      end else if (reg_flush) begin
         rx_vld <= 1'b0;
         rx_dat <= '0;
      end else if (state == RXA_XFER) begin
         rx_vld <= 1'b1;
`ifdef ALINK_RX_HDR_EN
         if (hdr_cycle) rx_dat <= rxa_hdr_word(cur_phy, seq);
         else
`endif
         rx_dat <= sel_dat;
      end else begin
         rx_vld <= 1'b0;
         rx_dat <= '0;
      end
   end

   // Sticky protocol error: granted PHY dropped its request mid-report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proto_err <= 1'b0;
      end else if (reg_flush) begin
         proto_err <= 1'b0;
      end else if ((state == RXA_XFER) && !req_cur) begin
         proto_err <= 1'b1;
      end
   end

endmodule
